// File: rtl/risc_pkg.sv
// Shared fetch-stage definitions: default widths, reset vector, PC step and the
// RUN/HALT state type.
package risc_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned INSTR_W    = 32;
    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
    localparam logic [31:0] PC_INC     = 32'd4;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC mux: aligned branch target, sequential +4, or hold,
// together with the misaligned-target fault flag.
module pc_next_sel
    import risc_pkg::*;
#(
    parameter int unsigned ADDR_W = risc_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              sel_branch,
    input  logic              sel_inc,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] next_pc,
    output logic              fault
);

    always_comb begin
        next_pc = pc;
        fault   = 1'b0;
        if (sel_branch) begin
            // Low bits are dropped, not trapped: the redirect still happens.
            next_pc = {branch_target[ADDR_W-1:2], 2'b00};
            fault   = |branch_target[1:0];
        end else if (sel_inc) begin
            next_pc = pc + ADDR_W'(PC_INC);
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and IF/ID register feeding decode, with branch redirect/flush,
// stall hold and a RUN/HALT control state.
module pc_fetch_unit
    import risc_pkg::*;
#(
    parameter int unsigned ADDR_W            = risc_pkg::ADDR_W,
    parameter int unsigned INSTR_W           = risc_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = ADDR_W'(risc_pkg::RESET_ADDR)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               halt_req,
    input  logic               resume,
    input  logic [INSTR_W-1:0] instruction_in,
    output logic [ADDR_W-1:0]  address_out,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               instr_valid,
    output logic               halted,
    output logic               align_fault
);

    fetch_state_t      state;
    logic              running;
    logic              sel_branch;
    logic              sel_inc;
    logic [ADDR_W-1:0] next_pc;
    logic              fault_next;

    always_comb begin
        running    = (state == RUN);
        sel_branch = running && branch_taken;
        sel_inc    = running && !branch_taken && !halt_req && !stall;
    end

    pc_next_sel #(
        .ADDR_W (ADDR_W)
    ) u_next_sel (
        .pc            (address_out),
        .sel_branch    (sel_branch),
        .sel_inc       (sel_inc),
        .branch_target (branch_target),
        .next_pc       (next_pc),
        .fault         (fault_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            address_out <= RESET_ADDR;
            instr_out   <= '0;
            pc_out      <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            align_fault <= 1'b0;
        end else begin
            // next_pc already encodes hold when neither select is active.
            address_out <= next_pc;
            align_fault <= fault_next;
            case (state)
                RUN: begin
                    if (branch_taken) begin
                        instr_valid <= 1'b0;
                        if (halt_req) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end
                    end else if (halt_req) begin
                        state       <= HALT;
                        halted      <= 1'b1;
                        instr_valid <= 1'b0;
                    end else if (!stall) begin
                        instr_out   <= instruction_in;
                        pc_out      <= address_out;
                        instr_valid <= 1'b1;
                    end
                end
                HALT: begin
                    instr_valid <= 1'b0;
                    if (resume && !halt_req) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed plus randomized bench for pc_fetch_unit, checked against a
// cycle-level reference model built from the fetch-stage rules.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, stall, branch_taken, halt_req, resume;
    logic [31:0] branch_target;
    logic [31:0] instruction_in;
    logic [31:0] address_out, instr_out, pc_out;
    logic        instr_valid, halted, align_fault;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pcout;
    logic        m_valid, m_halted, m_fault;

    pc_fetch_unit #(
        .ADDR_W     (32),
        .INSTR_W    (32),
        .RESET_ADDR (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .halt_req       (halt_req),
        .resume         (resume),
        .instruction_in (instruction_in),
        .address_out    (address_out),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .instr_valid    (instr_valid),
        .halted         (halted),
        .align_fault    (align_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'hA000_0000 | a;
    endfunction

    assign instruction_in = rom(address_out);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic st, input logic bt,
                              input logic [31:0] tg, input logic hr, input logic rs);
        if (r) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pcout = 32'h0;
            m_valid = 1'b0; m_halted = 1'b0; m_fault = 1'b0;
        end else if (!m_halted) begin
            m_fault = bt && (tg % 4 != 0);
            if (bt) begin
                m_pc    = tg - (tg % 4);
                m_valid = 1'b0;
                if (hr) m_halted = 1'b1;
            end else if (hr) begin
                m_halted = 1'b1;
                m_valid  = 1'b0;
            end else if (!st) begin
                m_instr = rom(m_pc);
                m_pcout = m_pc;
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
            end
        end else begin
            m_fault = 1'b0;
            m_valid = 1'b0;
            if (rs && !hr) m_halted = 1'b0;
        end
    endtask

    task automatic step(input logic r, input logic st, input logic bt,
                        input logic [31:0] tg, input logic hr, input logic rs);
        rst = r; stall = st; branch_taken = bt; branch_target = tg;
        halt_req = hr; resume = rs;
        @(posedge clk);
        model_step(r, st, bt, tg, hr, rs);
        #1;
        chk("address_out", address_out, m_pc);
        chk("instr_out", instr_out, m_instr);
        chk("pc_out", pc_out, m_pcout);
        chk("instr_valid", 32'(instr_valid), 32'(m_valid));
        chk("halted", 32'(halted), 32'(m_halted));
        chk("align_fault", 32'(align_fault), 32'(m_fault));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        halt_req = 1'b0; resume = 1'b0;

        // Reset and free-run
        step(1, 0, 0, 32'h0, 0, 0);
        step(1, 0, 0, 32'h0, 0, 0);
        chk("reset_addr", address_out, 32'h0);
        chk("reset_valid", 32'(instr_valid), 32'h0);
        run(1);
        chk("run_addr4", address_out, 32'h4);
        chk("first_instr", instr_out, 32'hA000_0000);
        chk("first_valid", 32'(instr_valid), 32'h1);
        run(1);
        chk("run_addr8", address_out, 32'h8);

        // Branch mid-stream
        step(0, 0, 1, 32'h40, 0, 0);
        chk("br_addr", address_out, 32'h40);
        chk("br_flush", 32'(instr_valid), 32'h0);
        run(1);
        chk("br_instr", instr_out, 32'hA000_0040);
        chk("br_pc", pc_out, 32'h40);

        // Stall with misaligned branch in the second stall cycle
        step(0, 0, 1, 32'h10, 0, 0);
        run(1);
        step(0, 1, 0, 32'h0, 0, 0);
        chk("stall1_addr", address_out, 32'h14);
        step(0, 1, 1, 32'h23, 0, 0);
        chk("stall2_addr", address_out, 32'h20);
        chk("stall2_fault", 32'(align_fault), 32'h1);
        step(0, 1, 0, 32'h0, 0, 0);
        chk("stall3_addr", address_out, 32'h20);
        chk("stall3_fault", 32'(align_fault), 32'h0);

        // Halt / resume with an ignored branch inside HALT
        step(0, 0, 1, 32'h14, 0, 0);
        step(0, 0, 0, 32'h0, 1, 0);
        chk("halt_on", 32'(halted), 32'h1);
        step(0, 0, 0, 32'h0, 0, 0);
        step(0, 0, 1, 32'h80, 0, 0);
        chk("halt_ignbr", address_out, 32'h14);
        step(0, 1, 0, 32'h0, 1, 0);
        step(0, 0, 0, 32'h0, 0, 0);
        chk("halt_hold", address_out, 32'h14);
        step(0, 0, 0, 32'h0, 0, 1);
        chk("resume_halted", 32'(halted), 32'h0);
        run(1);
        chk("resume_instr", instr_out, 32'hA000_0014);
        chk("resume_pc", pc_out, 32'h14);

        // Wrap-around
        step(0, 0, 1, 32'hFFFF_FFF8, 0, 0);
        run(1);
        chk("wrap_fffc", address_out, 32'hFFFF_FFFC);
        run(1);
        chk("wrap_zero", address_out, 32'h0);
        chk("wrap_nofault", 32'(align_fault), 32'h0);

        // Simultaneous events
        step(0, 0, 1, 32'h100, 1, 0);
        chk("brhalt_addr", address_out, 32'h100);
        chk("brhalt_halted", 32'(halted), 32'h1);
        step(0, 0, 0, 32'h0, 1, 1);
        chk("resume_halt_stay", 32'(halted), 32'h1);

        // Reset mid-halt and mid-stall
        step(1, 0, 0, 32'h0, 0, 0);
        chk("rst_halt_addr", address_out, 32'h0);
        chk("rst_halt_halted", 32'(halted), 32'h0);
        run(3);
        step(0, 1, 0, 32'h0, 0, 0);
        step(1, 1, 1, 32'h200, 0, 0);
        chk("rst_stall_addr", address_out, 32'h0);
        chk("rst_stall_valid", 32'(instr_valid), 32'h0);

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 64) == 0,
                 ($urandom % 4) == 0,
                 ($urandom % 8) == 0,
                 $urandom,
                 ($urandom % 16) == 0,
                 ($urandom % 4) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
